// File: rtl/instr_encoder_pkg.sv
// Shared RV32I field definitions used by the instruction encoder and decoder.
package instr_encoder_pkg;

  typedef enum logic [2:0] {
    FMT_R = 3'd0,
    FMT_I = 3'd1,
    FMT_S = 3'd2,
    FMT_B = 3'd3,
    FMT_U = 3'd4,
    FMT_J = 3'd5
  } fmt_e;

  localparam logic [1:0] OP_LOW = 2'b11;

  localparam logic [4:0] OP_IMM = 5'b00100;
  localparam logic [4:0] OP     = 5'b01100;
  localparam logic [4:0] STORE  = 5'b01000;
  localparam logic [4:0] BRANCH = 5'b11000;
  localparam logic [4:0] LUI    = 5'b01101;
  localparam logic [4:0] JAL    = 5'b11011;

  // True when v is representable as a signed value whose sign bit is v[msb].
  function automatic logic fits_signed(input logic [31:0] v, input int msb);
    logic signed [31:0] s;
    s = $signed(v) >>> msb;
    return (s == '0) || (s == '1);
  endfunction

endpackage

// File: rtl/instr_encoder_encode_imm.sv
// Scatters an immediate into its RV32I bit positions for the given format and
// flags immediates the format cannot represent.
module encode_imm
  import instr_encoder_pkg::*;
(
  input  logic [2:0]  fmt_i,
  input  logic [31:0] imm_i,
  output logic [31:0] imm_bits_o,
  output logic        illegal_o
);

  always_comb begin
    imm_bits_o = '0;
    illegal_o  = 1'b0;
    case (fmt_i)
      FMT_R: ;
      FMT_I: begin
        imm_bits_o[31:20] = imm_i[11:0];
        illegal_o         = !fits_signed(imm_i, 11);
      end
      FMT_S: begin
        imm_bits_o[31:25] = imm_i[11:5];
        imm_bits_o[11:7]  = imm_i[4:0];
        illegal_o         = !fits_signed(imm_i, 11);
      end
      FMT_B: begin
        imm_bits_o[31]    = imm_i[12];
        imm_bits_o[30:25] = imm_i[10:5];
        imm_bits_o[11:8]  = imm_i[4:1];
        imm_bits_o[7]     = imm_i[11];
        illegal_o         = !fits_signed(imm_i, 12) || imm_i[0];
      end
      FMT_U: begin
        imm_bits_o[31:12] = imm_i[31:12];
        illegal_o         = |imm_i[11:0];
      end
      FMT_J: begin
        imm_bits_o[31]    = imm_i[20];
        imm_bits_o[30:21] = imm_i[10:1];
        imm_bits_o[20]    = imm_i[11];
        imm_bits_o[19:12] = imm_i[19:12];
        illegal_o         = !fits_signed(imm_i, 20) || imm_i[0];
      end
      default: illegal_o = 1'b1;
    endcase
  end

endmodule

// File: rtl/instr_encoder.sv
// Streaming RV32I encoder: packs field bundles into words and writes them
// sequentially into IMEM through a single output register stage.
module instr_encoder
  import instr_encoder_pkg::*;
#(
  parameter int AW        = 10,
  parameter int BASE_ADDR = 0,
  parameter int DEPTH     = 1024
) (
  input  logic          CLK,
  input  logic          RST_X,
  input  logic          restart,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [2:0]    instr_format,
  input  logic [4:0]    opcode,
  input  logic [4:0]    rd,
  input  logic [4:0]    rs1,
  input  logic [4:0]    rs2,
  input  logic [2:0]    funct3,
  input  logic [6:0]    funct7,
  input  logic [31:0]   imm,
  output logic          mem_we,
  input  logic          mem_ready,
  output logic [AW-1:0] mem_addr,
  output logic [31:0]   mem_wdata,
  output logic [AW:0]   count,
  output logic          full,
  output logic          err,
  output logic [AW-1:0] err_addr
);

  localparam logic [AW-1:0] BASE_C  = AW'(BASE_ADDR);
  localparam logic [AW:0]   DEPTH_C = (AW+1)'(DEPTH);

  logic          we_q, we_d;
  logic [AW-1:0] addr_q, addr_d, err_addr_q, err_addr_d, slot;
  logic [31:0]   wdata_q, wdata_d, word, imm_bits;
  logic [AW:0]   count_q, count_d;
  logic          full_q, full_d, err_q, err_d;
  logic          illegal, done, block, accept;

  encode_imm u_encode_imm (
    .fmt_i      (instr_format),
    .imm_i      (imm),
    .imm_bits_o (imm_bits),
    .illegal_o  (illegal)
  );

  always_comb begin
    word = '0;
    case (instr_format)
      FMT_R:        word = {funct7, rs2, rs1, funct3, rd, opcode, OP_LOW};
      FMT_I:        word = {12'b0, rs1, funct3, rd, opcode, OP_LOW} | imm_bits;
      FMT_S, FMT_B: word = {7'b0, rs2, rs1, funct3, 5'b0, opcode, OP_LOW} | imm_bits;
      FMT_U, FMT_J: word = {20'b0, rd, opcode, OP_LOW} | imm_bits;
      default:      word = '0;
    endcase
  end

  // The pending word counts against capacity so the last slot is never overbooked.
  assign done     = we_q & mem_ready;
  assign block    = (count_q + {{AW{1'b0}}, we_q}) == DEPTH_C;
  assign in_ready = RST_X & ~restart & ~block & (~we_q | mem_ready);
  assign accept   = in_valid & in_ready;
  assign slot     = done ? addr_q + 1'b1 : addr_q;

  always_comb begin
    we_d       = we_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    count_d    = count_q;
    full_d     = full_q;
    err_d      = err_q;
    err_addr_d = err_addr_q;
    if (restart) begin
      we_d       = 1'b0;
      addr_d     = BASE_C;
      count_d    = '0;
      full_d     = 1'b0;
      err_d      = 1'b0;
      err_addr_d = '0;
    end else begin
      addr_d  = slot;
      count_d = count_q + {{AW{1'b0}}, done};
      full_d  = (count_d == DEPTH_C);
      if (accept) begin
        we_d = ~illegal;
        if (!illegal) wdata_d = word;
        // err_addr records only the first offending slot.
        if (illegal && !err_q) err_addr_d = slot;
        err_d = err_q | illegal;
      end else begin
        we_d = we_q & ~mem_ready;
      end
    end
  end

  always_ff @(posedge CLK or negedge RST_X) begin
    if (!RST_X) begin
      we_q       <= 1'b0;
      addr_q     <= BASE_C;
      wdata_q    <= '0;
      count_q    <= '0;
      full_q     <= 1'b0;
      err_q      <= 1'b0;
      err_addr_q <= '0;
    end else begin
      we_q       <= we_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      count_q    <= count_d;
      full_q     <= full_d;
      err_q      <= err_d;
      err_addr_q <= err_addr_d;
    end
  end

  assign mem_we    = we_q;
  assign mem_addr  = addr_q;
  assign mem_wdata = wdata_q;
  assign count     = count_q;
  assign full      = full_q;
  assign err       = err_q;
  assign err_addr  = err_addr_q;

endmodule
